// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: hex glyph table, segment bit positions
// and the output polarity helper.
package seg7_pkg;

  localparam int SEG_W = 7;

  // Segment bit positions within the {g,f,e,d,c,b,a} vector.
  typedef enum int {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } seg_bit_e;

  // Active-high glyphs for 0..F.
  localparam logic [SEG_W-1:0] HEX_SEG [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [SEG_W:0] apply_polarity(input logic [SEG_W:0] lvl,
                                                    input logic active_low);
    return active_low ? ~lvl : lvl;
  endfunction

endpackage

// File: rtl/seg7_hex_encode.sv
// Combinational hex-to-segment encoder with blanking and pin polarity applied.
module seg7_hex_encode
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0]       nibble,
  input  logic             blank,
  input  logic             dp,
  output logic [SEG_W-1:0] seg,
  output logic             dp_lvl
);

  logic [SEG_W-1:0] seg_hi;
  logic             dp_hi;

  always_comb begin
    seg_hi          = blank ? '0 : HEX_SEG[nibble];
    dp_hi           = dp & ~blank;
    {dp_lvl, seg}   = apply_polarity({dp_hi, seg_hi}, ACTIVE_LOW);
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scanner: PWM brightness with a dark phase 0,
// leading-zero blanking and frame-synchronous display updates.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int PWM_BITS    = 4,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_suppress,
  input  logic [PWM_BITS-1:0]     brightness,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [SEG_W-1:0]        segment,
  output logic                    dp_out,
  output logic                    frame_tick
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [SEG_W-1:0]      SEG_OFF   = {SEG_W{ACTIVE_LOW}};

  logic [DIV_W-1:0]    presc_p0;
  logic [PWM_BITS-1:0] phase_p0;
  logic [IDX_W-1:0]    idx_p0;
  logic                step_end, slot_end, frame_end;

  logic [4*NUM_DIGITS-1:0] pend_value, act_value;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
  logic [NUM_DIGITS-1:0]   pend_en, act_en;
  logic                    pend_lz, act_lz;
  logic [PWM_BITS-1:0]     pend_bright, act_bright;

  logic [NUM_DIGITS-1:0] supp;
  logic                  upper_zero;
  logic [3:0]            nib_p0;
  logic                  dp_sel_p0, en_sel_p0, supp_sel_p0, lit_p0;
  logic [NUM_DIGITS-1:0] onehot_p0, anode_lvl_p0;
  logic [SEG_W-1:0]      seg_lvl_p0;
  logic                  dp_lvl_p0;

  logic [NUM_DIGITS-1:0] anode_p1;
  logic [SEG_W-1:0]      segment_p1;
  logic                  dp_out_p1, frame_tick_p1;

  assign step_end  = (presc_p0 == DIV_LAST);
  assign slot_end  = step_end & (&phase_p0);
  assign frame_end = slot_end & (idx_p0 == IDX_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_p0 <= '0;
      phase_p0 <= '0;
      idx_p0   <= '0;
    end else begin
      presc_p0 <= step_end ? '0 : presc_p0 + 1'b1;
      if (step_end) phase_p0 <= phase_p0 + 1'b1;
      if (slot_end) idx_p0 <= frame_end ? '0 : idx_p0 + 1'b1;
    end
  end

  // Pending collects loads at any time; active only changes on the frame
  // boundary so a frame is never drawn from mixed data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_value  <= '0;
      pend_dp     <= '0;
      pend_en     <= '0;
      pend_lz     <= 1'b0;
      pend_bright <= '0;
      act_value   <= '0;
      act_dp      <= '0;
      act_en      <= '0;
      act_lz      <= 1'b0;
      act_bright  <= '0;
    end else begin
      if (load) begin
        pend_value  <= value;
        pend_dp     <= dp;
        pend_en     <= digit_en;
        pend_lz     <= lz_suppress;
        pend_bright <= brightness;
      end
      if (frame_end) begin
        act_value  <= pend_value;
        act_dp     <= pend_dp;
        act_en     <= pend_en;
        act_lz     <= pend_lz;
        act_bright <= pend_bright;
      end
    end
  end

  always_comb begin
    supp       = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero & (act_value[4*i +: 4] == 4'h0);
      supp[i]    = act_lz & upper_zero;
    end
  end

  // ---- stage p0: select current digit and decide whether it is lit ----
  always_comb begin
    nib_p0      = 4'h0;
    dp_sel_p0   = 1'b0;
    en_sel_p0   = 1'b0;
    supp_sel_p0 = 1'b0;
    onehot_p0   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_p0 == IDX_W'(i)) begin
        nib_p0       = act_value[4*i +: 4];
        dp_sel_p0    = act_dp[i];
        en_sel_p0    = act_en[i];
        supp_sel_p0  = supp[i];
        onehot_p0[i] = 1'b1;
      end
    end
  end

  assign lit_p0 = en_sel_p0 & ~supp_sel_p0 & (phase_p0 != '0) & (phase_p0 <= act_bright);
  assign anode_lvl_p0 = lit_p0 ? onehot_p0 : '0;

  seg7_hex_encode #(
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_encode (
    .nibble(nib_p0),
    .blank (~lit_p0),
    .dp    (dp_sel_p0),
    .seg   (seg_lvl_p0),
    .dp_lvl(dp_lvl_p0)
  );

  // ---- stage p1: registered pin drivers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode_p1      <= ANODE_OFF;
      segment_p1    <= SEG_OFF;
      dp_out_p1     <= ACTIVE_LOW;
      frame_tick_p1 <= 1'b0;
    end else begin
      anode_p1      <= ACTIVE_LOW ? ~anode_lvl_p0 : anode_lvl_p0;
      segment_p1    <= seg_lvl_p0;
      dp_out_p1     <= dp_lvl_p0;
      frame_tick_p1 <= frame_end;
    end
  end

  assign anode      = anode_p1;
  assign segment    = segment_p1;
  assign dp_out     = dp_out_p1;
  assign frame_tick = frame_tick_p1;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: 4 digits, 2-cycle PWM step, 2-bit PWM,
// active-low pins (slot = 8 cycles, frame = 32 cycles).
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic        lz_suppress;
  logic [1:0]  brightness;
  logic        load;
  logic [3:0]  anode;
  logic [6:0]  segment;
  logic        dp_out;
  logic        frame_tick;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(2),
    .PWM_BITS   (2),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .dp         (dp),
    .digit_en   (digit_en),
    .lz_suppress(lz_suppress),
    .brightness (brightness),
    .load       (load),
    .anode      (anode),
    .segment    (segment),
    .dp_out     (dp_out),
    .frame_tick (frame_tick)
  );

  // seg: expected pin pattern per digit {d3,d2,d1,d0}; dpx: expected dp_out pin
  // level per digit while lit; lit: digits expected to light at all.
  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        lz;
    logic [1:0]  bright;
    logic [27:0] seg;
    logic [3:0]  dpx;
    logic [3:0]  lit;
  } vec_t;

  vec_t vecs [10];
  vec_t rec_a;
  vec_t rec_blank;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic do_load(input vec_t v, input logic decoy);
    @(negedge clk);
    value       = decoy ? ~v.value : v.value;
    dp          = decoy ? ~v.dp : v.dp;
    digit_en    = decoy ? 4'hF : v.en;
    lz_suppress = decoy ? 1'b0 : v.lz;
    brightness  = decoy ? 2'd3 : v.bright;
    load        = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_ft();
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (frame_tick) seen = 1'b1;
    end
    check("wait_frame_tick", 32'(seen), 32'd1);
  endtask

  // Called right after the negedge on which frame_tick is seen; checks every
  // cycle of the following frame and that the next tick lands on cycle 32.
  task automatic check_frame(input vec_t v, input string tag);
    logic [11:0] exp;
    int ft_hits;
    int d;
    int off;
    ft_hits = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      load = 1'b0;
      d   = k / 8;
      off = k % 8;
      if (v.lit[d] && off >= 2 && off < 2 + 2 * int'(v.bright))
        exp = {~(4'b0001 << d), v.seg[7*d +: 7], v.dpx[d]};
      else
        exp = {4'hF, 7'h7F, 1'b1};
      check($sformatf("%s d%0d k%0d", tag, d, off), 32'({anode, segment, dp_out}), 32'(exp));
      if (frame_tick) ft_hits += (k == 31) ? 1 : 100;
    end
    check({tag, " frame_tick"}, 32'(ft_hits), 32'd1);
  endtask

  task automatic count_to_ft(input string tag);
    int n;
    int lit_seen;
    logic seen;
    n = 0;
    lit_seen = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (anode !== 4'hF) lit_seen++;
      if (frame_tick) seen = 1'b1;
    end
    check({tag, " first_tick_cycles"}, 32'(n), 32'd32);
    check({tag, " blank_while_waiting"}, 32'(lit_seen), 32'd0);
  endtask

  task automatic check_dark(input string tag);
    check({tag, " anode"}, 32'(anode), 32'h0000000F);
    check({tag, " segment"}, 32'(segment), 32'h0000007F);
    check({tag, " dp_out"}, 32'(dp_out), 32'd1);
    check({tag, " frame_tick"}, 32'(frame_tick), 32'd0);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'b0001, 4'hF, 1'b0, 2'd3, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1110, 4'hF};
    vecs[1] = '{16'h1234, 4'b0001, 4'hF, 1'b0, 2'd1, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1110, 4'hF};
    vecs[2] = '{16'h1234, 4'b0001, 4'hF, 1'b0, 2'd0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1110, 4'hF};
    vecs[3] = '{16'h0050, 4'b0000, 4'hF, 1'b1, 2'd3, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111, 4'b0011};
    vecs[4] = '{16'h0000, 4'b0000, 4'hF, 1'b1, 2'd3, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111, 4'b0001};
    vecs[5] = '{16'h1234, 4'b0000, 4'b0101, 1'b0, 2'd3, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 4'b0101};
    vecs[6] = '{16'h1000, 4'b0000, 4'hF, 1'b1, 2'd3, {7'h79, 7'h40, 7'h40, 7'h40}, 4'b1111, 4'hF};
    vecs[7] = '{16'hF0A0, 4'b1010, 4'hF, 1'b1, 2'd2, {7'h0E, 7'h40, 7'h08, 7'h40}, 4'b0101, 4'hF};
    vecs[8] = '{16'h89BC, 4'b1111, 4'hF, 1'b0, 2'd3, {7'h00, 7'h10, 7'h03, 7'h46}, 4'b0000, 4'hF};
    vecs[9] = '{16'h7DE6, 4'b0000, 4'hF, 1'b0, 2'd3, {7'h78, 7'h21, 7'h06, 7'h02}, 4'b1111, 4'hF};
    rec_a     = '{16'hAAAA, 4'b0000, 4'hF, 1'b0, 2'd3, {7'h08, 7'h08, 7'h08, 7'h08}, 4'b1111, 4'hF};
    rec_blank = '{16'h0000, 4'b0000, 4'h0, 1'b0, 2'd0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1111, 4'h0};

    reset       = 1'b1;
    value       = '0;
    dp          = '0;
    digit_en    = '0;
    lz_suppress = 1'b0;
    brightness  = '0;
    load        = 1'b0;

    repeat (3) @(negedge clk);
    check_dark("in_reset");
    reset = 1'b0;
    count_to_ft("power_on");

    for (int i = 0; i < 10; i++) begin
      do_load(vecs[i], 1'b1);
      do_load(vecs[i], 1'b0);
      wait_ft();
      check_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // Load on the tick cycle: old pending shows first, new data one frame later.
    value       = rec_a.value;
    dp          = rec_a.dp;
    digit_en    = rec_a.en;
    lz_suppress = rec_a.lz;
    brightness  = rec_a.bright;
    load        = 1'b1;
    check_frame(vecs[9], "coincide_old");
    check_frame(rec_a, "coincide_new");

    // Asynchronous reset while a digit is lit.
    begin
      int n;
      n = 0;
      while (anode === 4'hF && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("mid_run_lit_before_reset", 32'(anode !== 4'hF), 32'd1);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_dark("async_reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    count_to_ft("after_reset");
    check_frame(rec_blank, "post_reset_blank");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised, time-multiplexed seven-segment display controller for the Basys3-class board top level. It replaces the fixed 4-digit divider, counter and mux chain with one block. The block scans `NUM_DIGITS` common-anode digits, decodes hex nibbles, and adds per-digit enable, decimal points, leading-zero suppression, PWM brightness, anti-ghosting dead time and tear-free frame-synchronous updates. It sits between the switch/debounce logic and the `anode`/`segment` pins.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned, ≥2.
- `REFRESH_DIV`, 100000: clk cycles per PWM step, ≥2.
- `PWM_BITS`, 4: PWM phase width. One digit slot = `2**PWM_BITS` steps.
- `ACTIVE_LOW`, 1: 1 means `anode`, `segment` and `dp_out` are driven low when asserted.

- `clk` in 1: single clock. All logic runs on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `value` in 4*`NUM_DIGITS`: hex nibbles. Nibble i drives digit i; digit 0 is least significant.
- `dp` in `NUM_DIGITS`: decimal point per digit.
- `digit_en` in `NUM_DIGITS`: per-digit enable. 0 blanks the digit.
- `lz_suppress` in 1: enables leading-zero blanking.
- `brightness` in `PWM_BITS`: duty level. 0 = off.
- `load` in 1: one-cycle strobe that captures `value`, `dp`, `digit_en`, `lz_suppress` and `brightness`.
- `anode` out `NUM_DIGITS`: digit selects. Exactly one asserted or none.
- `segment` out 7: bit order {g,f,e,d,c,b,a}, with bit0 = a.
- `dp_out` out 1: decimal point.
- `frame_tick` out 1: one-cycle pulse at each frame boundary.

## Operation
- **Capture.** `load`=1 copies all inputs into a pending register.
- **Frame latch.** At each frame boundary the pending register is copied into the active register. The display only ever uses the active register.
- **Counters.**
  - The prescaler counts 0..`REFRESH_DIV`-1 and wraps.
  - On prescaler wrap, the `pwm_phase` counter (`PWM_BITS` wide) increments.
  - On `pwm_phase` wrap (all-ones → 0), `digit_idx` advances. It wraps `NUM_DIGITS`-1 → 0.
- **Frame boundary.** The cycle in which `digit_idx` wraps to 0. `frame_tick`=1 on that cycle.
- **Digit lit condition.** Digit `digit_idx` is lit iff all of the following hold:
  - `digit_en`[i]=1;
  - the digit is not suppressed;
  - 1 ≤ `pwm_phase` ≤ `brightness`.
- **Dead time.** Phase 0 is always dark. This is the anti-ghosting gap.
- **Duty.** Duty = `brightness`/2**`PWM_BITS`. The maximum is (2**P−1)/2**P.
- **Leading-zero suppression.** With `lz_suppress`=1, digit i>0 is suppressed iff nibble i and all nibbles above it are 0. Digit 0 is never suppressed. Suppression is evaluated on the active register.
- **Dark outputs.** When no digit is lit: `anode` all inactive, `segment` all inactive, `dp_out` inactive.
- **Decode.** Standard hex patterns, active-high: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.
  - When `ACTIVE_LOW`=1, all outputs are inverted.
  - `dp_out` follows `dp`[i] while the digit is lit.
- **Load coincident with frame boundary.** The pending register takes the new data. The active register takes the old pending data. The new data shows from the next frame.
- **Multiple loads within a frame.** The last one wins.

## Timing
- **Reset values.** Prescaler, `pwm_phase`, `digit_idx` = 0. Pending and active registers = 0, so `digit_en`=0 and the display is blank. `frame_tick`=0.
  - `anode`, `segment` and `dp_out` go inactive asynchronously: all ones when `ACTIVE_LOW`=1.
- **Output registers.** `anode`, `segment`, `dp_out` and `frame_tick` are registered.
  - They reflect counter state with 1 cycle of latency.
  - They never glitch between slots.
- **Periods.**
  - Slot = `REFRESH_DIV`·2**`PWM_BITS` cycles.
  - Frame = `NUM_DIGITS`·slot.
  - The first `frame_tick` after reset occurs one frame after release.
- **Reset mid-operation.** All state returns to reset values immediately. Scanning restarts at digit 0, phase 0.

## Structure
- **Package `seg7_pkg`:**
  - the 16-entry hex→segment constant table (active-high);
  - segment bit-index constants;
  - a polarity-apply function.
- **Sub-module `seg7_hex_encode`:** combinational. Inputs are a nibble, the blank condition, `dp` and `ACTIVE_LOW`; outputs are the segment and dp levels.
- **Remaining logic, kept in `seg7_scan_ctrl`:** prescaler, PWM/digit counters, pending/active registers, suppression logic and output registers.

## Test plan
Parameters for all scenarios: `NUM_DIGITS`=4, `REFRESH_DIV`=2, `PWM_BITS`=2, `ACTIVE_LOW`=1. This gives slot = 8 cycles and frame = 32 cycles.

1. **Reset.** Assert `reset` mid-run → `anode`=4'hF, `segment`=7'h7F, `dp_out`=1 immediately. `frame_tick` is first seen 32 cycles after release. The display stays blank.
2. **Basic scan.** `load` `value`=16'h1234, `digit_en`=4'hF, `brightness`=3, `dp`=4'b0001 → after the next `frame_tick`, the digit-0 slot shows `anode`=4'b1110, `segment`=7'h19, `dp_out`=0 for 6 of 8 cycles, dark for the first 2 cycles. Digit 3 shows `anode`=4'b0111, `segment`=7'h79.
3. **Brightness.** `brightness`=1 → each digit is lit 2 of 8 cycles. `brightness`=0 → `anode`=4'hF for the whole frame.
4. **Leading-zero suppression.** `lz_suppress`=1:
   - `value`=16'h0050 → digits 3 and 2 dark; digit 1 `segment`=7'h12; digit 0 `segment`=7'h40.
   - `value`=16'h0000 → only digit 0 is lit, showing `segment`=7'h40.
5. **Load at frame boundary.** `load` 16'hAAAA in the same cycle as `frame_tick` → the next frame shows the old value. The frame after shows `segment`=7'h08 on all digits.
6. **Per-digit enable.** `digit_en`=4'b0101 → `anode` only ever takes 4'b1110 and 4'b1011. It is 4'hF during the slots for digits 1 and 3.
